// File: rtl/cic_comb_chain_if.sv
// Sample-stream handshakes around the CIC comb chain: the input side from the
// sample source and the output side toward the zero-stuffer/integrators.
interface cic_comb_chain_if #(
  parameter int IN_W     = 16,
  parameter int N_STAGES = 3
);
  localparam int OUT_W = IN_W + N_STAGES;

  logic signed [IN_W-1:0]  in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;

  // master: sample source plus downstream sink; slave: the comb chain itself
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/cic_comb_chain.sv
// Cascaded CIC comb stages y[n] = x[n] - x[n-M], one register and one bit of
// growth per stage, advancing per accepted sample under a full-stall handshake.
module cic_comb_chain #(
  parameter int IN_W       = 16,
  parameter int N_STAGES   = 3,
  parameter int DIFF_DELAY = 1
) (
  input logic             clk,
  input logic             rst,
  input logic             clr,
  cic_comb_chain_if.slave io
);
  localparam int OUT_W = IN_W + N_STAGES;

  // Stage k is IN_W+k+1 bits wide; this is its LSB position in the packed bus.
  function automatic int stage_off(input int k);
    return k * IN_W + (k * (k + 1)) / 2;
  endfunction

  localparam int BUS_W = stage_off(N_STAGES);

  logic [BUS_W-1:0]    w_bus;
  logic [N_STAGES-1:0] w_v;
  logic                w_adv;
  logic                w_flush;

  assign w_flush      = rst | clr;
  assign w_adv        = ~w_v[N_STAGES-1] | io.out_ready;
  assign io.in_ready  = w_adv;
  assign io.out_valid = w_v[N_STAGES-1];
  assign io.out_data  = w_bus[stage_off(N_STAGES-1) +: OUT_W];

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    localparam int XW = IN_W + k;
    localparam int YW = XW + 1;

    logic signed [XW-1:0] w_x;
    logic                 w_xv;
    logic signed [XW-1:0] r_tap [DIFF_DELAY];
    logic signed [YW-1:0] r_data;
    logic                 r_valid;

    if (k == 0) begin : g_src
      assign w_x  = io.in_data;
      assign w_xv = io.in_valid;
    end else begin : g_src
      assign w_x  = w_bus[stage_off(k-1) +: XW];
      assign w_xv = w_v[k-1];
    end

    // Taps hold the last M stage inputs (tap 0 newest); they only move on a real sample.
    always_ff @(posedge clk) begin
      if (w_flush) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        for (int j = 0; j < DIFF_DELAY; j++) begin
          r_tap[j] <= '0;
        end
      end else if (w_adv) begin
        r_valid <= w_xv;
        if (w_xv) begin
          r_data   <= {w_x[XW-1], w_x}
                    - {r_tap[DIFF_DELAY-1][XW-1], r_tap[DIFF_DELAY-1]};
          r_tap[0] <= w_x;
          for (int j = 1; j < DIFF_DELAY; j++) begin
            r_tap[j] <= r_tap[j-1];
          end
        end
      end
    end

    assign w_bus[stage_off(k) +: YW] = r_data;
    assign w_v[k]                    = r_valid;
  end
endmodule

// File: tb/tb_cic_comb_chain.sv
// Bench for cic_comb_chain: M=1 and M=2 instances driven in lockstep, checked
// every cycle against a binomial-coefficient reference plus literal vectors.
module tb_cic_comb_chain;
  localparam int IN_W  = 16;
  localparam int NS    = 3;
  localparam int OUT_W = IN_W + NS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic                   clr;
  logic signed [IN_W-1:0] tb_in_data;
  logic                   tb_in_valid;
  logic                   tb_out_ready;
  logic                   chk_on;

  int errors = 0;
  int checks = 0;

  cic_comb_chain_if #(.IN_W(IN_W), .N_STAGES(NS)) if1 ();
  cic_comb_chain_if #(.IN_W(IN_W), .N_STAGES(NS)) if2 ();

  assign if1.in_data   = tb_in_data;
  assign if1.in_valid  = tb_in_valid;
  assign if1.out_ready = tb_out_ready;
  assign if2.in_data   = tb_in_data;
  assign if2.in_valid  = tb_in_valid;
  assign if2.out_ready = tb_out_ready;

  cic_comb_chain #(.IN_W(IN_W), .N_STAGES(NS), .DIFF_DELAY(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr), .io(if1)
  );
  cic_comb_chain #(.IN_W(IN_W), .N_STAGES(NS), .DIFF_DELAY(2)) u_dut2 (
    .clk(clk), .rst(rst), .clr(clr), .io(if2)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: newest sample convolved with signed binomial coefficients of (1 - z^-M)^NS.
  function automatic longint comb_ref(input longint h[$], input int m);
    longint y = 0;
    longint c = 1;
    int     n = h.size() - 1;
    for (int i = 0; i <= NS; i++) begin
      if (n - i * m >= 0) y += c * h[n - i * m];
      c = (-c * (NS - i)) / (i + 1);
    end
    return y;
  endfunction

  function automatic longint at(input longint q[$], input int i);
    return (i < q.size()) ? q[i] : 64'sd999999999;
  endfunction

  longint hist1[$], exp1[$], log1[$];
  longint hist2[$], exp2[$], log2[$];
  logic   hold1 = 1'b0, hold2 = 1'b0;
  longint hdata1 = 0, hdata2 = 0;

  // Scoreboard for the M=1 instance.
  always @(negedge clk) begin
    if (chk_on) begin
      if (if1.out_valid) begin
        if (exp1.size() == 0) chk("m1_unexpected_valid", longint'(if1.out_valid), 0);
        else chk("m1_out_data", if1.out_data, exp1[0]);
      end
      chk("m1_in_ready", longint'(if1.in_ready), longint'(!if1.out_valid || tb_out_ready));
      if (hold1) begin
        chk("m1_hold_valid", longint'(if1.out_valid), 1);
        chk("m1_hold_data", if1.out_data, hdata1);
      end
    end
    hold1  <= if1.out_valid && !tb_out_ready && !rst && !clr;
    hdata1 <= if1.out_data;
    if (rst || clr) begin
      exp1.delete();
      hist1.delete();
    end else begin
      if (if1.out_valid && tb_out_ready) begin
        log1.push_back(if1.out_data);
        if (exp1.size() > 0) void'(exp1.pop_front());
      end
      if (tb_in_valid && if1.in_ready) begin
        hist1.push_back(tb_in_data);
        exp1.push_back(comb_ref(hist1, 1));
      end
    end
  end

  // Scoreboard for the M=2 instance.
  always @(negedge clk) begin
    if (chk_on) begin
      if (if2.out_valid) begin
        if (exp2.size() == 0) chk("m2_unexpected_valid", longint'(if2.out_valid), 0);
        else chk("m2_out_data", if2.out_data, exp2[0]);
      end
      chk("m2_in_ready", longint'(if2.in_ready), longint'(!if2.out_valid || tb_out_ready));
      if (hold2) begin
        chk("m2_hold_valid", longint'(if2.out_valid), 1);
        chk("m2_hold_data", if2.out_data, hdata2);
      end
    end
    hold2  <= if2.out_valid && !tb_out_ready && !rst && !clr;
    hdata2 <= if2.out_data;
    if (rst || clr) begin
      exp2.delete();
      hist2.delete();
    end else begin
      if (if2.out_valid && tb_out_ready) begin
        log2.push_back(if2.out_data);
        if (exp2.size() > 0) void'(exp2.pop_front());
      end
      if (tb_in_valid && if2.in_ready) begin
        hist2.push_back(tb_in_data);
        exp2.push_back(comb_ref(hist2, 2));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    tb_in_valid = 1'b0;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    log1.delete();
    log2.delete();
  endtask

  task automatic send(input logic signed [IN_W-1:0] d, input string tag);
    bit acc = 1'b0;
    tb_in_data  = d;
    tb_in_valid = 1'b1;
    for (int c = 0; c < 60 && !acc; c++) begin
      @(negedge clk);
      acc = if1.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk({tag, "_accept_timeout"}, longint'(if1.in_ready), 1);
    tb_in_valid = 1'b0;
  endtask

  longint exp_t1[6]  = '{1, -3, 3, -1, 0, 0};
  longint exp_t2[9]  = '{1, 0, -3, 0, 3, 0, -1, 0, 0};
  longint exp_t4[6]  = '{100, -200, 100, 0, 0, 0};
  longint exp_t5[5]  = '{1, -3, 3, -1, 0};
  int     lat;
  int     stall_seen;

  initial begin
    rst = 1'b1; clr = 1'b0; chk_on = 1'b0;
    tb_in_valid = 1'b0; tb_in_data = '0; tb_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", longint'(if1.out_valid), 0);
    chk("reset_out_data", if1.out_data, 0);
    chk("reset_in_ready", longint'(if1.in_ready), 1);
    chk("reset_m2_out_valid", longint'(if2.out_valid), 0);
    chk_on = 1'b1;
    cyc();

    // Impulse, in_valid every clock; latency and both impulse responses.
    tb_in_data = 16'sd1; tb_in_valid = 1'b1;
    @(negedge clk);
    chk("t1_first_accept", longint'(if1.in_ready), 1);
    @(posedge clk); #1;
    tb_in_data = 16'sd0;
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (if1.out_valid) lat = c;
    end
    chk("t1_latency", lat, 3);
    repeat (10) cyc();
    tb_in_valid = 1'b0;
    repeat (8) cyc();
    for (int i = 0; i < 6; i++) chk($sformatf("t1_out%0d", i), at(log1, i), exp_t1[i]);
    for (int i = 0; i < 9; i++) chk($sformatf("t2_out%0d", i), at(log2, i), exp_t2[i]);

    // Full-scale alternating input: exact 19-bit extremes, no wrap.
    do_clr();
    tb_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tb_in_data = (i % 2 == 0) ? 16'sh7fff : 16'sh8000;
      cyc();
    end
    tb_in_valid = 1'b0;
    repeat (8) cyc();
    chk("t3_count", log1.size(), 20);
    chk("t3_out18", at(log1, 18), 262140);
    chk("t3_out19", at(log1, 19), -262140);
    chk("t3_m2_out19", at(log2, 19), 0);

    // Step of 100 with random input gaps and a 5-clock downstream stall.
    do_clr();
    stall_seen = 0;
    fork
      begin
        for (int s = 0; s < 12; s++) begin
          repeat ($urandom_range(0, 1)) cyc();
          send(16'sd100, "t4");
        end
      end
      begin
        for (int c = 0; c < 200 && log1.size() < 3; c++) cyc();
        tb_out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (if1.out_valid && !if1.in_ready) stall_seen++;
          cyc();
        end
        tb_out_ready = 1'b1;
      end
    join
    repeat (8) cyc();
    chk("t4_stall_seen", longint'(stall_seen > 0), 1);
    chk("t4_count", log1.size(), 12);
    for (int i = 0; i < 6; i++) chk($sformatf("t4_out%0d", i), at(log1, i), exp_t4[i]);

    // clr in the middle of an impulse response, then a fresh impulse.
    do_clr();
    tb_in_data = 16'sd1; tb_in_valid = 1'b1;
    cyc();
    tb_in_data = 16'sd0;
    for (int c = 0; c < 40 && log1.size() < 2; c++) cyc();
    tb_in_valid = 1'b0;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    @(negedge clk);
    chk("t5_valid_after_clr", longint'(if1.out_valid), 0);
    chk("t5_m2_valid_after_clr", longint'(if2.out_valid), 0);
    chk("t5_count_before_clr", log1.size(), 2);
    chk("t5_last_before_clr", at(log1, 1), -3);
    cyc();
    tb_in_data = 16'sd1; tb_in_valid = 1'b1;
    cyc();
    tb_in_data = 16'sd0;
    repeat (8) cyc();
    tb_in_valid = 1'b0;
    repeat (8) cyc();
    for (int i = 0; i < 5; i++) chk($sformatf("t5_out%0d", i), at(log1, i + 2), exp_t5[i]);

    // rst while stalled with a sample offered: everything in flight is dropped.
    do_clr();
    tb_out_ready = 1'b0;
    tb_in_data = 16'sd5; tb_in_valid = 1'b1;
    repeat (6) cyc();
    @(negedge clk);
    chk("t6_stalled_in_ready", longint'(if1.in_ready), 0);
    chk("t6_stalled_out_valid", longint'(if1.out_valid), 1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    tb_in_valid = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", longint'(if1.out_valid), 0);
    chk("t6_out_data", if1.out_data, 0);
    chk("t6_in_ready", longint'(if1.in_ready), 1);
    cyc();
    tb_out_ready = 1'b1;
    repeat (6) cyc();
    chk("t6_no_output", log1.size(), 0);

    chk("end_m1_pending", exp1.size(), 0);
    chk("end_m2_pending", exp2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end
endmodule
